// File: rtl/csub_serial_pkg.sv
// Shared definitions for the block-serial subtractor (csub_serial).
// Holds the sequencer state type and the block-counter width helper.
package csub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the block counter: clog2(size/subsize), but never below one bit.
  function automatic int cnt_width(input int size, input int subsize);
    int nblk;
    nblk = size / subsize;
    return (nblk <= 1) ? 1 : $clog2(nblk);
  endfunction

endpackage

// File: rtl/csub_serial_if.sv
// Handshake and operand bus between a sequencer (master) and csub_serial (slave).
// The ovf signal exists only when CSUB_SERIAL_OVF_EN is defined.
interface csub_serial_if #(
  parameter int size = 16
) ();

  logic            start;
  logic [size:1]   a;
  logic [size:1]   b;
  logic            bin;
  logic            busy;
  logic            done;
  logic [size:1]   diff;
  logic            bout;
`ifdef CSUB_SERIAL_OVF_EN
  logic            ovf;
`endif

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
`ifdef CSUB_SERIAL_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
`ifdef CSUB_SERIAL_OVF_EN
    , output ovf
`endif
  );

endinterface

// File: rtl/csub_serial_block.sv
// csub_block: combinational subsize-bit carry-skip subtract slice.
// Computes a + ~b + ~bin; a block-wide propagate term bypasses the ripple chain.
module csub_block #(
  parameter int subsize = 4
) (
  input  logic [subsize-1:0] a,
  input  logic [subsize-1:0] b,
  input  logic               bin,
  output logic [subsize-1:0] diff,
  output logic               bout,
  output logic               cmsb
);

  logic [subsize-1:0] p;
  logic [subsize-1:0] g;
  logic               blk_p;
  logic               ripple_cout;

  // Per-bit propagate/generate against the inverted subtrahend.
  generate
    for (genvar gi = 0; gi < subsize; gi++) begin : g_bit
      assign p[gi] = a[gi] ^ ~b[gi];
      assign g[gi] = a[gi] & ~b[gi];
    end
  endgenerate

  assign blk_p = &p;

  // Ripple the carry through the block; also capture the carry into the MSB.
  always_comb begin
    logic cc;
    cc   = ~bin;
    diff = '0;
    cmsb = 1'b0;
    for (int i = 0; i < subsize; i++) begin
      if (i == subsize - 1) cmsb = cc;
      diff[i] = p[i] ^ cc;
      cc      = g[i] | (p[i] & cc);
    end
    ripple_cout = cc;
  end

  // Skip path: a fully propagating block passes its carry-in straight through.
  assign bout = ~(blk_p ? ~bin : ripple_cout);

endmodule

// File: rtl/csub_serial.sv
// csub_serial: multi-cycle block-serial subtractor, diff = a - b - bin.
// One subsize-bit block per clock, LSB block first, start/busy/done handshake.
// Optional macro CSUB_SERIAL_OVF_EN adds a signed-overflow output (ovf).
module csub_serial
  import csub_pkg::*;
#(
  parameter int size    = 16,
  parameter int subsize = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  csub_serial_if.slave bus
);

  localparam int NBLK = size / subsize;
  localparam int CW   = cnt_width(size, subsize);
  localparam logic [CW-1:0] LAST_BLK = CW'(NBLK - 1);

  state_t              state_reg;
  logic [CW-1:0]       cnt_reg;
  logic [size-1:0]     a_reg;
  logic [size-1:0]     b_reg;
  logic [size-1:0]     res_reg;
  logic [size-1:0]     diff_reg;
  logic                borrow_reg;
  logic                bout_reg;
  logic                done_reg;

  logic [subsize-1:0]  a_slice;
  logic [subsize-1:0]  b_slice;
  logic [subsize-1:0]  blk_diff;
  logic                blk_bout;
  logic                blk_cmsb;

  assign a_slice = a_reg[int'(cnt_reg) * subsize +: subsize];
  assign b_slice = b_reg[int'(cnt_reg) * subsize +: subsize];

  csub_block #(
    .subsize (subsize)
  ) u_block (
    .a    (a_slice),
    .b    (b_slice),
    .bin  (borrow_reg),
    .diff (blk_diff),
    .bout (blk_bout),
    .cmsb (blk_cmsb)
  );

`ifdef CSUB_SERIAL_OVF_EN
  logic ovf_work_reg;
  logic ovf_reg;

  // Track overflow of the most recent block; the last block's value is the answer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_work_reg <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      if (state_reg == RUN) ovf_work_reg <= blk_cmsb ^ ~blk_bout;
      if (state_reg == DONE) ovf_reg <= ovf_work_reg;
    end
  end

  assign bus.ovf = ovf_reg;
`else
  logic unused_cmsb;
  assign unused_cmsb = blk_cmsb;
`endif

  // Sequencer: latch operands, walk the blocks, then publish the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      res_reg    <= '0;
      diff_reg   <= '0;
      borrow_reg <= 1'b0;
      bout_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          // A start in the done-pulse cycle is ignored; earliest accept is one cycle later.
          if (bus.start && !done_reg) begin
            a_reg      <= bus.a;
            b_reg      <= bus.b;
            borrow_reg <= bus.bin;
            cnt_reg    <= '0;
            state_reg  <= RUN;
          end
        end
        RUN: begin
          res_reg[int'(cnt_reg) * subsize +: subsize] <= blk_diff;
          borrow_reg <= blk_bout;
          cnt_reg    <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_BLK) state_reg <= DONE;
        end
        DONE: begin
          diff_reg  <= res_reg;
          bout_reg  <= borrow_reg;
          done_reg  <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state_reg == RUN);
  assign bus.done = done_reg;
  assign bus.diff = diff_reg;
  assign bus.bout = bout_reg;

endmodule

// File: tb/tb_csub_serial.sv
// Self-checking bench for csub_serial (size=16, subsize=4).
// Expected results come from plain arithmetic on the operands.
// Define CSUB_SERIAL_OVF_EN to also check the overflow output.
module tb_csub_serial;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  csub_serial_if #(.size(16)) bus ();

  csub_serial #(
    .size    (16),
    .subsize (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: 17-bit difference; bit 16 is the borrow out.
  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b, input logic bin);
    return {1'b0, a} - {1'b0, b} - {16'd0, bin};
  endfunction

  // Reference signed overflow: true result outside the 16-bit two's-complement range.
  function automatic logic model_ovf(input logic [15:0] a, input logic [15:0] b, input logic bin);
    int r;
    r = int'($signed(a)) - int'($signed(b)) - int'(bin);
    return (r > 32767) || (r < -32768);
  endfunction

  // Issue one operation and watch it until done (or a cycle budget runs out).
  // lat is the count of edges after the start edge until done is seen (-1 on timeout).
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tbin,
                       input bit hammer, output int lat, output int busy_cnt,
                       output bit partial, output logic done_prev);
    logic [16:1] pd;
    logic        pb;
    @(negedge clk);
    done_prev = bus.done;
    pd        = bus.diff;
    pb        = bus.bout;
    bus.start = 1'b1;
    bus.a     = ta;
    bus.b     = tb_;
    bus.bin   = tbin;
    lat       = -1;
    busy_cnt  = 0;
    partial   = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        lat = j;
        break;
      end
      if (bus.diff !== pd || bus.bout !== pb) partial = 1'b1;
      bus.start = hammer;
      bus.a     = 16'($urandom);
      bus.b     = 16'($urandom);
      bus.bin   = 1'($urandom);
    end
    if (!hammer) bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.diff !== 16'h0 || bus.bout !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b done=%b diff=%h bout=%b, required 0 0 0000 0",
               bus.busy, bus.done, bus.diff, bus.bout);
    end
`ifdef CSUB_SERIAL_OVF_EN
    checks++;
    if (bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf: ovf=%b, required 0", bus.ovf);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [15:0] ta [4] = '{16'h1234, 16'h0000, 16'hFFFF, 16'h0000};
    logic [15:0] tb_[4] = '{16'h0234, 16'h0001, 16'h0000, 16'h0000};
    logic        tbn[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [15:0] xd [4] = '{16'h1000, 16'hFFFF, 16'hFFFE, 16'hFFFF};
    logic        xb [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int lat, bc;
    bit part;
    logic dp;
    for (int i = 0; i < 4; i++) begin
      do_op(ta[i], tb_[i], tbn[i], 1'b0, lat, bc, part, dp);
      checks++;
      if (lat !== 5) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got %0d edges, required 5", i, lat);
      end
      checks++;
      if (bc !== 4) begin
        errors++;
        $display("FAIL directed_busy[%0d]: busy for %0d cycles, required 4", i, bc);
      end
      checks++;
      if (part) begin
        errors++;
        $display("FAIL directed_hold[%0d]: diff/bout changed before done, required stable", i);
      end
      checks++;
      if (bus.diff !== xd[i] || bus.bout !== xb[i]) begin
        errors++;
        $display("FAIL directed_result[%0d]: diff=%h bout=%b, required diff=%h bout=%b",
                 i, bus.diff, bus.bout, xd[i], xb[i]);
      end
      $display("op %h - %h - %b -> diff=%h bout=%b lat=%0d", ta[i], tb_[i], tbn[i], bus.diff, bus.bout, lat);
    end
  endtask

  task automatic test_random();
    int lat, bc;
    bit part;
    logic dp;
    logic [15:0] ra, rb;
    logic rbin;
    logic [16:0] exp_r;
    for (int i = 0; i < 30; i++) begin
      ra    = 16'($urandom);
      rb    = 16'($urandom);
      rbin  = 1'($urandom);
      exp_r = model(ra, rb, rbin);
      do_op(ra, rb, rbin, 1'b0, lat, bc, part, dp);
      checks++;
      if (lat !== 5 || bus.diff !== exp_r[15:0] || bus.bout !== exp_r[16]) begin
        errors++;
        $display("FAIL random[%0d]: %h-%h-%b lat=%0d diff=%h bout=%b, required lat=5 diff=%h bout=%b",
                 i, ra, rb, rbin, lat, bus.diff, bus.bout, exp_r[15:0], exp_r[16]);
      end
`ifdef CSUB_SERIAL_OVF_EN
      checks++;
      if (bus.ovf !== model_ovf(ra, rb, rbin)) begin
        errors++;
        $display("FAIL random_ovf[%0d]: ovf=%b, required %b", i, bus.ovf, model_ovf(ra, rb, rbin));
      end
`endif
      $display("op %h - %h - %b -> diff=%h bout=%b", ra, rb, rbin, bus.diff, bus.bout);
    end
  endtask

  task automatic test_start_while_busy();
    int lat, bc;
    bit part;
    logic dp;
    logic [16:0] exp_r;
    exp_r = model(16'hA5C3, 16'h3C5A, 1'b1);
    do_op(16'hA5C3, 16'h3C5A, 1'b1, 1'b1, lat, bc, part, dp);
    checks++;
    if (lat !== 5 || bus.diff !== exp_r[15:0] || bus.bout !== exp_r[16]) begin
      errors++;
      $display("FAIL busy_ignore: lat=%0d diff=%h bout=%b, required lat=5 diff=%h bout=%b",
               lat, bus.diff, bus.bout, exp_r[15:0], exp_r[16]);
    end
    // start is still high through the done cycle; it must not launch a new op.
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL done_cycle_ignore: busy=%b done=%b, required 0 0", bus.busy, bus.done);
    end
    $display("hammered op -> diff=%h bout=%b lat=%0d", bus.diff, bus.bout, lat);
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    bit part;
    logic dp;
    logic [16:0] exp_r;
    do_op(16'h4321, 16'h1111, 1'b0, 1'b0, lat, bc, part, dp);
    exp_r = model(16'h0100, 16'h0200, 1'b0);
    do_op(16'h0100, 16'h0200, 1'b0, 1'b0, lat, bc, part, dp);
    checks++;
    if (dp !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse_width: done=%b one cycle after done, required 0", dp);
    end
    checks++;
    if (lat !== 5 || bus.diff !== exp_r[15:0] || bus.bout !== exp_r[16]) begin
      errors++;
      $display("FAIL back_to_back: lat=%0d diff=%h bout=%b, required lat=5 diff=%h bout=%b",
               lat, bus.diff, bus.bout, exp_r[15:0], exp_r[16]);
    end
    $display("back-to-back op -> diff=%h bout=%b lat=%0d", bus.diff, bus.bout, lat);
  endtask

  task automatic test_reset_abort();
    int lat, bc, seen_done;
    bit part;
    logic dp;
    logic [16:0] exp_r;
    do_op(16'h9876, 16'h0001, 1'b0, 1'b0, lat, bc, part, dp);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'h5555;
    bus.b     = 16'h1234;
    bus.bin   = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    // Third RUN cycle: pull reset and look before any clock edge.
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.diff !== 16'h0 || bus.bout !== 1'b0) begin
      errors++;
      $display("FAIL abort_async: busy=%b done=%b diff=%h bout=%b, required 0 0 0000 0",
               bus.busy, bus.done, bus.diff, bus.bout);
    end
    seen_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.done) seen_done++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.done) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin
      errors++;
      $display("FAIL abort_no_done: %0d done pulses, required 0", seen_done);
    end
    exp_r = model(16'h0F0F, 16'h00FF, 1'b1);
    do_op(16'h0F0F, 16'h00FF, 1'b1, 1'b0, lat, bc, part, dp);
    checks++;
    if (lat !== 5 || bus.diff !== exp_r[15:0] || bus.bout !== exp_r[16]) begin
      errors++;
      $display("FAIL after_abort: lat=%0d diff=%h bout=%b, required lat=5 diff=%h bout=%b",
               lat, bus.diff, bus.bout, exp_r[15:0], exp_r[16]);
    end
    $display("op after abort -> diff=%h bout=%b lat=%0d", bus.diff, bus.bout, lat);
  endtask

`ifdef CSUB_SERIAL_OVF_EN
  task automatic test_ovf();
    int lat, bc;
    bit part;
    logic dp;
    do_op(16'h8000, 16'h0001, 1'b0, 1'b0, lat, bc, part, dp);
    checks++;
    if (bus.diff !== 16'h7FFF || bus.ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: diff=%h ovf=%b, required 7fff 1", bus.diff, bus.ovf);
    end
    do_op(16'h0005, 16'h0003, 1'b0, 1'b0, lat, bc, part, dp);
    checks++;
    if (bus.diff !== 16'h0002 || bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: diff=%h ovf=%b, required 0002 0", bus.diff, bus.ovf);
    end
    $display("ovf op -> diff=%h ovf=%b", bus.diff, bus.ovf);
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed();
    test_random();
    test_start_while_busy();
    test_back_to_back();
    test_reset_abort();
`ifdef CSUB_SERIAL_OVF_EN
    test_ovf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
